// File: rtl/crosshair_overlay.sv
// rtl/crosshair_overlay.sv - latches tracked target per frame, overlays a crosshair, runs the shot/flash/cooldown FSM
module crosshair_overlay #(
    parameter int ARM          = 8,
    parameter int FLASH_FRAMES = 4,
    parameter int COOL_FRAMES  = 30,
    parameter int LOST_FRAMES  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    input  logic [10:0] tgt_x,
    input  logic [10:0] tgt_y,
    input  logic        tgt_found,
    input  logic        trigger,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        locked,
    output logic        shot_valid,
    output logic [10:0] shot_x,
    output logic [10:0] shot_y,
    output logic        busy
);
    localparam int MW   = $clog2(LOST_FRAMES + 1);
    localparam int FMAX = (FLASH_FRAMES > COOL_FRAMES) ? FLASH_FRAMES : COOL_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLASH = 2'd1;
    localparam logic [1:0] S_COOL  = 2'd2;

    logic          prev_origin_q, prev_origin_d;
    logic          trig_s1_q, trig_s1_d, trig_s2_q, trig_s2_d, trig_s3_q, trig_s3_d;
    logic [10:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic          locked_q, locked_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [10:0]   o_x_q, o_x_d, o_y_q, o_y_d;
    logic [7:0]    o_r_q, o_r_d, o_g_q, o_g_d, o_b_q, o_b_d;
    logic          shot_valid_q, shot_valid_d;
    logic [10:0]   shot_x_q, shot_x_d, shot_y_q, shot_y_d;
    logic          busy_q, busy_d;

    logic          origin, frame_tick, trig_edge, hit;
    logic [11:0]   dx, dy;
    logic [7:0]    ov_r, ov_g, ov_b;

    always_comb begin
        origin     = (x == 11'd0) && (y == 11'd0);
        frame_tick = origin && !prev_origin_q;
        trig_edge  = trig_s2_q && !trig_s3_q;

        // 12-bit magnitude so arms near the screen edge never alias to the far side
        dx  = (x >= cur_x_q) ? ({1'b0, x} - {1'b0, cur_x_q}) : ({1'b0, cur_x_q} - {1'b0, x});
        dy  = (y >= cur_y_q) ? ({1'b0, y} - {1'b0, cur_y_q}) : ({1'b0, cur_y_q} - {1'b0, y});
        hit = ((y == cur_y_q) && (dx <= 12'(ARM))) || ((x == cur_x_q) && (dy <= 12'(ARM)));

        ov_r = 8'd0;
        ov_g = 8'd255;
        ov_b = 8'd0;
        if (state_q == S_FLASH) begin
            ov_r = 8'd255;
            ov_g = 8'd0;
        end else if (state_q == S_COOL) begin
            ov_r = 8'd128;
            ov_g = 8'd128;
            ov_b = 8'd128;
        end

        prev_origin_d = origin;
        trig_s1_d     = trigger;
        trig_s2_d     = trig_s1_q;
        trig_s3_d     = trig_s2_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        locked_d      = locked_q;
        miss_d        = miss_q;
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        shot_valid_d  = 1'b0;
        shot_x_d      = shot_x_q;
        shot_y_d      = shot_y_q;

        if (frame_tick) begin
            if (tgt_found) begin
                cur_x_d  = tgt_x;
                cur_y_d  = tgt_y;
                locked_d = 1'b1;
                miss_d   = '0;
            end else begin
                if (miss_q != MW'(LOST_FRAMES))
                    miss_d = miss_q + MW'(1);
                if (miss_d == MW'(LOST_FRAMES))
                    locked_d = 1'b0;
            end
        end

        // Shot coordinates come from the _q copy, so a coincident tick cannot leak in
        case (state_q)
            S_IDLE: begin
                if (trig_edge && locked_q) begin
                    shot_valid_d = 1'b1;
                    shot_x_d     = cur_x_q;
                    shot_y_d     = cur_y_q;
                    fcnt_d       = '0;
                    state_d      = S_FLASH;
                end
            end
            S_FLASH: begin
                if (frame_tick) begin
                    if (fcnt_q + FW'(1) == FW'(FLASH_FRAMES)) begin
                        state_d = S_COOL;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            S_COOL: begin
                if (frame_tick) begin
                    if (fcnt_q + FW'(1) == FW'(COOL_FRAMES)) begin
                        state_d = S_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        o_x_d  = x;
        o_y_d  = y;
        o_r_d  = (hit && locked_q) ? ov_r : iR;
        o_g_d  = (hit && locked_q) ? ov_g : iG;
        o_b_d  = (hit && locked_q) ? ov_b : iB;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_origin_q <= 1'b0;
            trig_s1_q     <= 1'b0;
            trig_s2_q     <= 1'b0;
            trig_s3_q     <= 1'b0;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            locked_q      <= 1'b0;
            miss_q        <= '0;
            state_q       <= S_IDLE;
            fcnt_q        <= '0;
            o_x_q         <= '0;
            o_y_q         <= '0;
            o_r_q         <= '0;
            o_g_q         <= '0;
            o_b_q         <= '0;
            shot_valid_q  <= 1'b0;
            shot_x_q      <= '0;
            shot_y_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            prev_origin_q <= prev_origin_d;
            trig_s1_q     <= trig_s1_d;
            trig_s2_q     <= trig_s2_d;
            trig_s3_q     <= trig_s3_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            locked_q      <= locked_d;
            miss_q        <= miss_d;
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            o_x_q         <= o_x_d;
            o_y_q         <= o_y_d;
            o_r_q         <= o_r_d;
            o_g_q         <= o_g_d;
            o_b_q         <= o_b_d;
            shot_valid_q  <= shot_valid_d;
            shot_x_q      <= shot_x_d;
            shot_y_q      <= shot_y_d;
            busy_q        <= busy_d;
        end
    end

    assign oX         = o_x_q;
    assign oY         = o_y_q;
    assign oR         = o_r_q;
    assign oG         = o_g_q;
    assign oB         = o_b_q;
    assign locked     = locked_q;
    assign shot_valid = shot_valid_q;
    assign shot_x     = shot_x_q;
    assign shot_y     = shot_y_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_crosshair_overlay.sv
// tb/tb_crosshair_overlay.sv - directed scenario with randomized pixels against a frame-level reference model
module tb_crosshair_overlay;
    localparam int ARM = 8, FLASH_FRAMES = 4, COOL_FRAMES = 30, LOST_FRAMES = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic [10:0] x = '0, y = '0, tx = '0, ty = '0;
    logic [7:0]  ir = '0, ig = '0, ib = '0;
    logic        tf = 1'b0, trig = 1'b0;
    logic [10:0] oX, oY, shot_x, shot_y;
    logic [7:0]  oR, oG, oB;
    logic        locked, shot_valid, busy;

    int errors = 0, checks = 0;

    // reference model: mode 0 idle, 1 flash, 2 cooldown; m_left counts frames remaining
    int m_cx, m_cy, m_miss, m_mode, m_left, m_sx, m_sy;
    bit m_locked, m_prev_origin, h0, h1, h2;
    int fx = 0, fy = 0;
    bit fixed_col = 1'b0;

    always #5 clk = ~clk;

    crosshair_overlay #(.ARM(ARM), .FLASH_FRAMES(FLASH_FRAMES), .COOL_FRAMES(COOL_FRAMES),
                        .LOST_FRAMES(LOST_FRAMES)) dut (
        .clock(clk), .reset(rst), .x(x), .y(y), .iR(ir), .iG(ig), .iB(ib),
        .tgt_x(tx), .tgt_y(ty), .tgt_found(tf), .trigger(trig),
        .oX(oX), .oY(oY), .oR(oR), .oG(oG), .oB(oB), .locked(locked),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y), .busy(busy));

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_cx = 0; m_cy = 0; m_miss = 0; m_mode = 0; m_left = 0; m_sx = 0; m_sy = 0;
        m_locked = 0; m_prev_origin = 0; h0 = 0; h1 = 0; h2 = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int px, input int py);
        logic [7:0]  er, eg, eb;
        logic [70:0] e, o;
        bit tick, te, hit, sv;
        x = 11'(px);
        y = 11'(py);
        tick = (px == 0 && py == 0) && !m_prev_origin;
        te   = h1 && !h2;
        hit  = m_locked && ((py == m_cy && iabs(px - m_cx) <= ARM) ||
                            (px == m_cx && iabs(py - m_cy) <= ARM));
        er = hit ? ((m_mode == 1) ? 8'd255 : (m_mode == 2) ? 8'd128 : 8'd0) : ir;
        eg = hit ? ((m_mode == 0) ? 8'd255 : (m_mode == 2) ? 8'd128 : 8'd0) : ig;
        eb = hit ? ((m_mode == 2) ? 8'd128 : 8'd0) : ib;
        sv = 0;
        if (m_mode == 0) begin
            if (te && m_locked) begin
                sv = 1; m_sx = m_cx; m_sy = m_cy; m_mode = 1; m_left = FLASH_FRAMES;
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                if (m_mode == 1) begin m_mode = 2; m_left = COOL_FRAMES; end
                else m_mode = 0;
            end
        end
        if (tick) begin
            if (tf) begin
                m_cx = int'(tx); m_cy = int'(ty); m_locked = 1; m_miss = 0;
            end else begin
                if (m_miss < LOST_FRAMES) m_miss++;
                if (m_miss == LOST_FRAMES) m_locked = 0;
            end
        end
        m_prev_origin = (px == 0 && py == 0);
        h2 = h1; h1 = h0; h0 = trig;
        @(posedge clk); #1;
        e = {11'(px), 11'(py), er, eg, eb, m_locked, sv, 11'(m_sx), 11'(m_sy), (m_mode != 0)};
        o = {oX, oY, oR, oG, oB, locked, shot_valid, shot_x, shot_y, busy};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL pixel(%0d,%0d) observed=%h expected=%h", px, py, o, e);
        end
    endtask

    task automatic rand_pix();
        int px, py, off, sel;
        off = int'($urandom_range(0, 24)) - 12;
        sel = int'($urandom_range(0, 2));
        if (sel == 0) begin px = fx + off; py = fy; end
        else if (sel == 1) begin px = fx; py = fy + off; end
        else begin px = fx + off; py = fy + int'($urandom_range(0, 24)) - 12; end
        px = px & 2047;
        py = py & 2047;
        if (px == 0 && py == 0) px = 1;
        if (!fixed_col) begin
            ir = 8'($urandom); ig = 8'($urandom); ib = 8'($urandom);
        end
        step(px, py);
    endtask

    task automatic frame(input int n);
        step(0, 0);
        step(1, 0);
        for (int i = 0; i < n; i++) rand_pix();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({oX, oY, oR, oG, oB, locked, shot_valid, shot_x, shot_y, busy} != 0), 32'd0);
        rst = 1'b0;

        // pass-through while nothing is tracked
        fixed_col = 1; ir = 8'd10; ig = 8'd20; ib = 8'd30;
        fx = 100; fy = 50;
        frame(20);
        frame(20);
        chk("locked_idle", 32'(locked), 32'd0);

        // acquire (100,50) and probe the arm ends
        tx = 11'd100; ty = 11'd50; tf = 1'b1;
        frame(10);
        step(0, 0);
        step(100, 50);  chk("centre_g", 32'(oG), 32'd255);
        step(92, 50);   chk("arm_left_g", 32'(oG), 32'd255);
        step(108, 50);  chk("arm_right_g", 32'(oG), 32'd255);
        step(100, 42);  chk("arm_up_g", 32'(oG), 32'd255);
        step(100, 58);  chk("arm_down_r", 32'(oR), 32'd0);
        step(109, 50);  chk("past_arm_g", 32'(oG), 32'd20);
        step(91, 50);
        step(100, 59);
        fixed_col = 0;
        for (int i = 0; i < 20; i++) rand_pix();

        // lock is held through 7 missed ticks and drops on the 8th
        tf = 1'b0;
        for (int i = 1; i <= LOST_FRAMES; i++) begin
            step(0, 0);
            chk("locked_after_miss", 32'(locked), 32'(i < LOST_FRAMES));
            step(1, 0);
            for (int j = 0; j < 6; j++) rand_pix();
        end
        tf = 1'b1;
        frame(10);

        // shot, then flash/cooldown with stray trigger pulses that must be ignored
        trig = 1'b1;
        frame(12);
        chk("shot_x", 32'(shot_x), 32'd100);
        chk("shot_y", 32'(shot_y), 32'd50);
        trig = 1'b0;
        for (int i = 1; i <= FLASH_FRAMES + COOL_FRAMES; i++) begin
            step(0, 0);
            chk("busy_after_tick", 32'(busy), 32'(i < FLASH_FRAMES + COOL_FRAMES));
            if (i < FLASH_FRAMES + COOL_FRAMES - 3) trig = 1'($urandom);
            else trig = 1'b0;
            step(1, 0);
            for (int j = 0; j < 8; j++) rand_pix();
        end
        trig = 1'b0;
        frame(10);

        // target at the top-left corner: arms clip, nothing appears near 2047
        tx = 11'd2; ty = 11'd0; fx = 2; fy = 0;
        frame(10);
        step(0, 0);
        step(2047, 0);  chk("no_wrap_x", 32'(oG), 32'(ig));
        step(2, 2047);  chk("no_wrap_y", 32'(oG), 32'(ig));
        step(1, 0);
        for (int j = 0; j < 40; j++) rand_pix();

        // reset in the middle of a flash
        trig = 1'b1;
        frame(8);
        trig = 1'b0;
        frame(4);
        chk("busy_mid_flash", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        chk("reset_mid_flash", 32'({oX, oY, oR, oG, oB, locked, shot_valid, shot_x, shot_y, busy} != 0), 32'd0);
        model_reset();
        @(posedge clk); #1;
        chk("shot_valid_in_reset", 32'(shot_valid), 32'd0);
        rst = 1'b0;
        frame(10);
        frame(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
